risc_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the RISC_TOY pipeline family.
- Replaces the single IF register with:
  - a PC generator,
  - an instruction-memory request port,
  - a DEPTH-entry prefetch queue,
  - redirect (branch/jump) flush.
- Sits between instruction memory (IREQ/IADDR/INSTR) and the decode stage, which pops through a valid/ready handshake.

---
 rtl/risc_fetch_queue_if.sv | 25 ++
 rtl/risc_fetch_queue.sv | 113 +++++++++++
 tb/tb_risc_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/risc_fetch_queue_if.sv
// Fetch-front-end bus: instruction-memory request/response, decode pop handshake and EX redirect.
interface risc_fetch_queue_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;

    modport master (
        output IREQ, IADDR, out_valid, out_instr, out_pc,
        input  INSTR, out_ready, redir_valid, redir_pc
    );

    modport slave (
        input  IREQ, IADDR, out_valid, out_instr, out_pc,
        output INSTR, out_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/risc_fetch_queue.sv
// RISC_TOY fetch front end: PC generator, imem request port, DEPTH-entry prefetch queue, redirect flush.
// Optional saturating performance counters are built when FETCH_PERF_EN is defined.
module risc_fetch_queue #(
    parameter int            AW       = 30,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic                CLK,
    input logic                RSTN,
    risc_fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [AW-1:0] pc;
    logic [AW-1:0] req_pc_p1;
    logic          inflight;
    logic          run;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] q_instr [DEPTH];
    logic [AW-1:0] q_pc    [DEPTH];

    logic          ireq;
    logic          pop;
    logic          push;
    logic [OW-1:0] occ;

    // A response arriving on a redirect edge is stale and dies with the flush.
    always_comb begin
        bus.out_valid = (count != '0) && !bus.redir_valid;
        pop           = bus.out_valid && bus.out_ready;
        push          = inflight && !bus.redir_valid;
        occ           = OW'(count) + OW'(inflight) - OW'(pop);
        ireq          = run && !bus.redir_valid && (occ < OW'(DEPTH));
        bus.IREQ      = ireq;
        bus.IADDR     = pc;
        bus.out_instr = q_instr[rd_ptr];
        bus.out_pc    = q_pc[rd_ptr];
    end

    // Stage p0 -> p1: request issue and queue bookkeeping
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc        <= RESET_PC;
            req_pc_p1 <= '0;
            inflight  <= 1'b0;
            run       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= ireq;
            if (ireq) begin
                pc        <= pc + AW'(1);
                req_pc_p1 <= pc;
            end
            if (bus.redir_valid) begin
                pc     <= bus.redir_pc;
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Stage p1 -> queue: capture the memory response beside the PC it was fetched from
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= bus.INSTR;
            q_pc[wr_ptr]    <= req_pc_p1;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, 32'(push));
            perf_flushed <= sat_add(perf_flushed,
                                    bus.redir_valid ? (32'(count) + 32'(inflight)) : 32'd0);
            perf_stall   <= sat_add(perf_stall, 32'(run && !ireq && !bus.redir_valid));
        end
    end
`endif
endmodule

// File: tb/tb_risc_fetch_queue.sv
// Bench for risc_fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_risc_fetch_queue;
    localparam int            AW    = 30;
    localparam int            DW    = 32;
    localparam int            DEPTH = 4;
    localparam logic [AW-1:0] RPC   = 30'h10;

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ent_t          mq[$];
    logic [AW-1:0] issued[$];
    logic [AW-1:0] popped[$];
    bit            m_run;
    bit            m_pend;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_paddr;

    always #5 clk = ~clk;

    risc_fetch_queue_if #(.AW(AW), .DW(DW)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

    risc_fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK (clk),
        .RSTN(rstn),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_stall  (perf_stall)
`endif
    );

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return 32'hA000_0000 + {2'b00, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance model, answer memory after the edge.
    task automatic step(input bit rdy, input bit rv, input logic [AW-1:0] rpc);
        bit            e_valid, e_pop, e_ireq, d_ireq;
        int            occ;
        logic [AW-1:0] d_iaddr;
        ent_t          e;
        @(negedge clk);
        bus.out_ready   = rdy;
        bus.redir_valid = rv;
        bus.redir_pc    = rpc;
        #1;
        e_valid = (mq.size() != 0) && !rv;
        e_pop   = e_valid && rdy;
        occ     = mq.size() + int'(m_pend) - int'(e_pop);
        e_ireq  = m_run && !rv && (occ < DEPTH);
        check("ireq", 64'(bus.IREQ), 64'(e_ireq));
        if (e_ireq) check("iaddr", 64'(bus.IADDR), 64'(m_pc));
        check("out_valid", 64'(bus.out_valid), 64'(e_valid));
        if (e_valid) begin
            check("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
            check("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
        end
        d_ireq  = bus.IREQ;
        d_iaddr = bus.IADDR;
        if (d_ireq) issued.push_back(d_iaddr);
        if (bus.out_valid && rdy) popped.push_back(bus.out_pc);
        if (rv) begin
            mq.delete();
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_pend) begin
                e.instr = mem(m_paddr);
                e.pc    = m_paddr;
                mq.push_back(e);
            end
        end
        m_pend  = e_ireq;
        m_paddr = m_pc;
        if (rv) m_pc = rpc;
        else if (e_ireq) m_pc = m_pc + 1'b1;
        m_run = 1'b1;
        @(posedge clk);
        #1;
        bus.INSTR = d_ireq ? mem(d_iaddr) : DW'($urandom);
    endtask

    // Asynchronous reset mid-cycle; release mid-cycle so the next step sees run=0.
    task automatic apply_reset();
        bus.redir_valid = 1'b0;
        bus.out_ready   = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_ireq", 64'(bus.IREQ), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_pc", 64'(bus.out_pc), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
        check("rst_perf_flushed", 64'(perf_flushed), 64'd0);
        check("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
        mq.delete();
        issued.delete();
        popped.delete();
        m_pend = 1'b0;
        m_run  = 1'b0;
        m_pc   = RPC;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        int bad;
        bus.out_ready   = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        bus.INSTR       = '0;
        #2;
        apply_reset();

        // Free-running fetch from RESET_PC
        repeat (8) step(1'b1, 1'b0, '0);
        check("start_issue0", 64'(issued[0]), 64'h10);
        check("start_issue1", 64'(issued[1]), 64'h11);
        check("start_issue2", 64'(issued[2]), 64'h12);
        check("start_pop0", 64'(popped[0]), 64'h10);
        check("start_pop1", 64'(popped[1]), 64'h11);

        // Stalled decode fills the queue, then drains in order
        apply_reset();
        repeat (10) step(1'b0, 1'b0, '0);
        check("full_issue_count", 64'(issued.size()), 64'd4);
        repeat (8) step(1'b1, 1'b0, '0);
        check("drain_count_min", 64'(popped.size() >= 4), 64'd1);
        for (int i = 0; i < popped.size(); i++)
            check("drain_order", 64'(popped[i]), 64'(RPC + AW'(i)));

        // Redirect with a response in flight and three entries queued
        apply_reset();
        for (int k = 0; k < 12 && !(mq.size() == 3 && m_pend); k++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 30'h200);
        popped.delete();
        repeat (6) step(1'b1, 1'b0, '0);
        check("redir_first_pc", 64'(popped[0]), 64'h200);
        check("redir_second_pc", 64'(popped[1]), 64'h201);

        // Back-to-back redirects: the last one wins
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 30'h100);
        step(1'b1, 1'b1, 30'h300);
        popped.delete();
        repeat (6) step(1'b1, 1'b0, '0);
        check("b2b_first_pc", 64'(popped[0]), 64'h300);
        bad = 0;
        foreach (popped[i]) if (popped[i] >= 30'h100 && popped[i] < 30'h200) bad++;
        check("b2b_no_stale", 64'(bad), 64'd0);

        // PC wraps at the top of the address space
        step(1'b1, 1'b1, 30'h3FFF_FFFE);
        issued.delete();
        popped.delete();
        repeat (8) step(1'b1, 1'b0, '0);
        check("wrap_issue0", 64'(issued[0]), 64'h3FFF_FFFE);
        check("wrap_issue1", 64'(issued[1]), 64'h3FFF_FFFF);
        check("wrap_issue2", 64'(issued[2]), 64'h0);
        check("wrap_issue3", 64'(issued[3]), 64'h1);
        check("wrap_pop2", 64'(popped[2]), 64'h0);
        check("wrap_pop3", 64'(popped[3]), 64'h1);

        // Reset with two entries queued and a request in flight
        apply_reset();
        for (int k = 0; k < 12 && !(mq.size() == 2 && m_pend); k++) step(1'b0, 1'b0, '0);
        apply_reset();
        repeat (4) step(1'b1, 1'b0, '0);
        check("rerun_issue0", 64'(issued[0]), 64'(RPC));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] tgt;
            tgt = ($urandom % 2 != 0) ? AW'($urandom) : (30'h3FFF_FFF8 + AW'($urandom % 16));
            step(($urandom % 4) != 0, ($urandom % 10) == 0, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
